// File: rtl/eth_speed_pkg.sv
// Shared speed encoding and window-count classifier for the RGMII link-speed detector.
// Optional hysteresis is selected by ETH_SPEED_DET_HYST_EN in eth_link_speed_chan.
package eth_speed_pkg;

    typedef enum logic [1:0] {
        SPEED_10   = 2'b00,
        SPEED_100  = 2'b01,
        SPEED_1000 = 2'b10
    } eth_speed_e;

    typedef struct packed {
        logic       link;
        eth_speed_e speed;
    } eth_class_t;

    // The speed field is only meaningful when link is set.
    function automatic eth_class_t classify(input int unsigned n,
                                            input int unsigned link_min,
                                            input int unsigned t100,
                                            input int unsigned t1000);
        eth_class_t r;
        r.link = (n >= link_min);
        if (n < t100) begin
            r.speed = SPEED_10;
        end else if (n < t1000) begin
            r.speed = SPEED_100;
        end else begin
            r.speed = SPEED_1000;
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_link_speed_chan.sv
// One channel: toggle detect, saturating toggle count, window classification and output regs.
// ETH_SPEED_DET_HYST_EN adds a candidate/confirm stage in front of the speed register.
module eth_link_speed_chan
    import eth_speed_pkg::*;
#(
    parameter int unsigned CNT_W       = 9,
    parameter int unsigned LINK_MIN    = 2,
    parameter int unsigned THRESH_100  = 16,
    parameter int unsigned THRESH_1000 = 128,
    parameter int unsigned CONFIRM     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       window_done,
    input  logic       rx_div,
    output logic [1:0] speed,
    output logic       mii_select,
    output logic       link,
    output logic       speed_change
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             last;
    logic             tog;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] n;
    eth_class_t       cls;
    eth_speed_e       speed_q;
    eth_speed_e       next_speed;

    assign tog = rx_div ^ last;
    // n includes this cycle's toggle, so a toggle on the closing cycle counts in that window.
    assign n   = (tog && (count != CNT_MAX)) ? count + CNT_W'(1) : count;
    assign cls = classify(32'(n), LINK_MIN, THRESH_100, THRESH_1000);

`ifdef ETH_SPEED_DET_HYST_EN
    localparam int unsigned          CONF_W   = $clog2(CONFIRM + 1);
    localparam logic [CONF_W-1:0]    CONF_MAX = CONF_W'(CONFIRM);

    eth_speed_e        cand;
    logic [CONF_W-1:0] conf;
    logic [CONF_W-1:0] conf_next;

    always_comb begin
        conf_next  = CONF_W'(1);
        next_speed = speed_q;
        if (cls.speed == cand) begin
            conf_next = (conf == CONF_MAX) ? conf : conf + CONF_W'(1);
        end
        if (conf_next == CONF_MAX) begin
            next_speed = cls.speed;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand <= SPEED_10;
            conf <= '0;
        end else if (window_done) begin
            if (cls.link) begin
                cand <= cls.speed;
                conf <= conf_next;
            end else begin
                cand <= SPEED_10;
                conf <= '0;
            end
        end
    end
`else
    // Without hysteresis every linked window takes effect; CONFIRM has no role here.
    logic unused_confirm;
    assign unused_confirm = ^CONFIRM;
    assign next_speed     = cls.speed;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last         <= 1'b0;
            count        <= '0;
            speed_q      <= SPEED_1000;
            mii_select   <= 1'b0;
            link         <= 1'b0;
            speed_change <= 1'b0;
        end else begin
            last         <= rx_div;
            speed_change <= 1'b0;
            if (!enable) begin
                count <= '0;
            end else if (window_done) begin
                count        <= '0;
                link         <= cls.link;
                speed_change <= (cls.link != link) || (cls.link && (next_speed != speed_q));
                // No-link windows leave the last known speed in place.
                if (cls.link) begin
                    speed_q    <= next_speed;
                    mii_select <= (next_speed != SPEED_1000);
                end
            end else begin
                count <= n;
            end
        end
    end

    assign speed = speed_q;

endmodule

// File: rtl/eth_link_speed_detect.sv
// Multi-channel RGMII link-speed classifier: shared measurement window plus one eth_link_speed_chan
// per port. Hysteresis on speed updates is enabled by defining ETH_SPEED_DET_HYST_EN.
module eth_link_speed_detect
    import eth_speed_pkg::*;
#(
    parameter int unsigned CHANNELS      = 1,
    parameter int unsigned WINDOW_CYCLES = 1024,
    parameter int unsigned CNT_W         = 9,
    parameter int unsigned LINK_MIN      = 2,
    parameter int unsigned THRESH_100    = 16,
    parameter int unsigned THRESH_1000   = 128,
    parameter int unsigned CONFIRM       = 3
) (
    input  logic                    ref_clk,
    input  logic                    ref_rst_n,
    input  logic                    enable_i,
    input  logic [CHANNELS-1:0]     rx_div_i,
    output logic [2*CHANNELS-1:0]   speed_o,
    output logic [CHANNELS-1:0]     mii_select_o,
    output logic [CHANNELS-1:0]     link_o,
    output logic [CHANNELS-1:0]     speed_change_o,
    output logic                    window_done_o
);

    localparam int unsigned      WC_W    = $clog2(WINDOW_CYCLES);
    localparam logic [WC_W-1:0]  WC_LAST = WC_W'(WINDOW_CYCLES - 1);

    logic [WC_W-1:0] wc;
    logic            window_done;

    assign window_done   = enable_i && (wc == WC_LAST);
    assign window_done_o = window_done;

    // Dropping enable restarts the window from zero rather than pausing it.
    always_ff @(posedge ref_clk or negedge ref_rst_n) begin
        if (!ref_rst_n) begin
            wc <= '0;
        end else if (!enable_i || window_done) begin
            wc <= '0;
        end else begin
            wc <= wc + WC_W'(1);
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        eth_link_speed_chan #(
            .CNT_W       (CNT_W),
            .LINK_MIN    (LINK_MIN),
            .THRESH_100  (THRESH_100),
            .THRESH_1000 (THRESH_1000),
            .CONFIRM     (CONFIRM)
        ) u_chan (
            .clk          (ref_clk),
            .rst_n        (ref_rst_n),
            .enable       (enable_i),
            .window_done  (window_done),
            .rx_div       (rx_div_i[c]),
            .speed        (speed_o[2*c +: 2]),
            .mii_select   (mii_select_o[c]),
            .link         (link_o[c]),
            .speed_change (speed_change_o[c])
        );
    end

endmodule

// File: tb/tb_eth_link_speed_detect.sv
// Directed-plus-random bench for eth_link_speed_detect (2 channels); the model follows
// ETH_SPEED_DET_HYST_EN when it is defined.
module tb_eth_link_speed_detect;

    localparam int CH  = 2;
    localparam int WIN = 1024;
`ifdef ETH_SPEED_DET_HYST_EN
    localparam int CONFIRM_EFF = 3;
`else
    localparam int CONFIRM_EFF = 1;
`endif

    logic            clk = 1'b0;
    logic            ref_rst_n;
    logic            enable_i;
    logic [CH-1:0]   rx_div_i;
    logic [2*CH-1:0] speed_o;
    logic [CH-1:0]   mii_select_o;
    logic [CH-1:0]   link_o;
    logic [CH-1:0]   speed_change_o;
    logic            window_done_o;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: what each output should show at the next sample point.
    logic [1:0]    exp_speed [CH];
    logic [CH-1:0] exp_mii;
    logic [CH-1:0] exp_link;
    logic [CH-1:0] exp_change;
    logic [1:0]    hist      [CH][16];
    int            hist_len  [CH];
    bit            flips     [CH][WIN];

    always #5 clk = ~clk;

    eth_link_speed_detect #(
        .CHANNELS      (CH),
        .WINDOW_CYCLES (WIN),
        .CNT_W         (9),
        .LINK_MIN      (2),
        .THRESH_100    (16),
        .THRESH_1000   (128),
        .CONFIRM       (3)
    ) dut (
        .ref_clk        (clk),
        .ref_rst_n      (ref_rst_n),
        .enable_i       (enable_i),
        .rx_div_i       (rx_div_i),
        .speed_o        (speed_o),
        .mii_select_o   (mii_select_o),
        .link_o         (link_o),
        .speed_change_o (speed_change_o),
        .window_done_o  (window_done_o)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] class_of(input int n);
        if (n < 16)  return 2'b00;
        if (n < 128) return 2'b01;
        return 2'b10;
    endfunction

    task automatic reset_model();
        for (int c = 0; c < CH; c++) begin
            exp_speed[c] = 2'b10;
            hist_len[c]  = 0;
        end
        exp_mii    = '0;
        exp_link   = '0;
        exp_change = '0;
    endtask

    // Outcome of a closed window in which channel c saw n[c] toggles.
    task automatic model_window(input int n0, input int n1);
        int         n [CH];
        int         ne;
        logic [1:0] cls;
        logic [1:0] old_s;
        logic       old_l;
        bit         agree;
        n[0] = n0;
        n[1] = n1;
        for (int c = 0; c < CH; c++) begin
            ne    = (n[c] > 511) ? 511 : n[c];
            cls   = class_of(ne);
            old_s = exp_speed[c];
            old_l = exp_link[c];
            if (ne < 2) begin
                exp_link[c] = 1'b0;
                hist_len[c] = 0;
            end else begin
                exp_link[c] = 1'b1;
                for (int i = 15; i > 0; i--) hist[c][i] = hist[c][i-1];
                hist[c][0] = cls;
                if (hist_len[c] < 16) hist_len[c]++;
                agree = (hist_len[c] >= CONFIRM_EFF);
                for (int i = 0; i < CONFIRM_EFF; i++) begin
                    if (agree && hist[c][i] != cls) agree = 1'b0;
                end
                if (agree) exp_speed[c] = cls;
                exp_mii[c] = (exp_speed[c] != 2'b10);
            end
            exp_change[c] = (old_s != exp_speed[c]) || (old_l != exp_link[c]);
        end
    endtask

    // Sample on the falling edge, then the caller drives the next cycle's inputs.
    task automatic tick(input bit exp_wd);
        @(negedge clk);
        check("window_done", 8'(window_done_o), 8'(exp_wd));
        for (int c = 0; c < CH; c++) begin
            check($sformatf("speed[%0d]", c), 8'(speed_o[2*c +: 2]), 8'(exp_speed[c]));
            check($sformatf("mii_select[%0d]", c), 8'(mii_select_o[c]), 8'(exp_mii[c]));
            check($sformatf("link[%0d]", c), 8'(link_o[c]), 8'(exp_link[c]));
            check($sformatf("speed_change[%0d]", c), 8'(speed_change_o[c]), 8'(exp_change[c]));
        end
        exp_change = '0;
    endtask

    task automatic gen_flips(input int c, input int n, input bit force_last);
        int cnt;
        int p;
        cnt = 0;
        for (int k = 0; k < WIN; k++) flips[c][k] = 1'b0;
        if (force_last && n > 0) begin
            flips[c][WIN-1] = 1'b1;
            cnt = 1;
        end
        while (cnt < n) begin
            p = $urandom_range(0, force_last ? WIN - 2 : WIN - 1);
            if (!flips[c][p]) begin
                flips[c][p] = 1'b1;
                cnt++;
            end
        end
    endtask

    task automatic run_window(input int n0, input int n1, input bit force_last);
        gen_flips(0, n0, force_last);
        gen_flips(1, n1, force_last);
        for (int k = 0; k < WIN; k++) begin
            tick(k == WIN - 1);
            enable_i = 1'b1;
            for (int c = 0; c < CH; c++) rx_div_i[c] = rx_div_i[c] ^ flips[c][k];
        end
        model_window(n0, n1);
    endtask

    task automatic run_phase(input int n0, input int n1, input bit force_last, input int reps);
        for (int r = 0; r < reps; r++) run_window(n0, n1, force_last);
    endtask

    task automatic run_partial(input int m, input bit en);
        for (int k = 0; k < m; k++) begin
            tick(1'b0);
            enable_i = en;
            rx_div_i = CH'($urandom);
        end
    endtask

    task automatic pulse_reset(input int cycles);
        tick(1'b0);
        ref_rst_n = 1'b0;
        enable_i  = 1'b0;
        reset_model();
        for (int k = 0; k < cycles; k++) begin
            tick(1'b0);
            rx_div_i = CH'($urandom);
        end
        tick(1'b0);
        ref_rst_n = 1'b1;
        rx_div_i  = '0;
    endtask

    initial begin
        #(5_000_000);
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        ref_rst_n = 1'b1;
        enable_i  = 1'b0;
        rx_div_i  = '0;
        #2;
        ref_rst_n = 1'b0;
        reset_model();
        // Reset held with rx toggling: outputs stay at reset values.
        for (int k = 0; k < 6; k++) begin
            tick(1'b0);
            rx_div_i = CH'($urandom);
        end
        tick(1'b0);
        ref_rst_n = 1'b1;
        rx_div_i  = '0;

        // 512 toggles saturates the counter at 511: 1000M, link rises once.
        run_phase(512, 512, 1'b0, 3);
        // 100M on ch0, 1000M->100M on ch1.
        run_phase(51, $urandom_range(16, 127), 1'b0, 3);
        // 10M on ch0, back to 1000M on ch1.
        run_phase(5, $urandom_range(128, 511), 1'b0, 3);
        // Static / below LINK_MIN: link drops, speed held.
        run_phase(0, 1, 1'b0, 2);
        // Link regained; ch1 exactly at LINK_MIN.
        run_phase($urandom_range(128, 600), 2, 1'b0, 3);
        // Threshold boundaries with a toggle on the closing cycle.
        run_phase(16, 127, 1'b1, 3);
        run_phase(15, 128, 1'b1, 3);
        // Alternating classes.
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) run_window(51, 256, 1'b0);
            else            run_window(256, 51, 1'b0);
        end
        // Enable drop mid-window: partial window discarded.
        run_partial(500, 1'b1);
        run_partial(37, 1'b0);
        run_phase(5, 51, 1'b0, 3);
        // Reset mid-window.
        run_partial(300, 1'b1);
        pulse_reset(3);
        run_phase(256, 20, 1'b0, 3);
        // Random windows.
        for (int i = 0; i < 4; i++) run_window($urandom_range(0, 600), $urandom_range(0, 600), 1'b0);
        tick(1'b0);
        tick(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
